// File: rtl/controller_pkg.sv
// Shared types and opcode constants for the multi-cycle controller.
package controller_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Class prefixes and full opcodes
  localparam logic [1:0] CLS_RTYPE = 2'b00;
  localparam logic [1:0] CLS_ITYPE = 2'b01;
  localparam logic [2:0] CLS_LW    = 3'b100;
  localparam logic [2:0] CLS_SW    = 3'b101;
  localparam logic [3:0] CLS_SHIFT = 4'b1100;

  localparam logic [OPCODE_W-1:0] OP_JMP  = 6'b110100;
  localparam logic [OPCODE_W-1:0] OP_BZ   = 6'b110101;
  localparam logic [OPCODE_W-1:0] OP_BNZ  = 6'b110110;
  localparam logic [OPCODE_W-1:0] OP_BC   = 6'b110111;
  localparam logic [OPCODE_W-1:0] OP_BNC  = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;

  localparam logic [1:0] BR_Z  = 2'd0;
  localparam logic [1:0] BR_NZ = 2'd1;
  localparam logic [1:0] BR_C  = 2'd2;
  localparam logic [1:0] BR_NC = 2'd3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;

  typedef struct packed {
    logic       is_rtype;
    logic       is_itype;
    logic       is_lw;
    logic       is_sw;
    logic       is_shift;
    logic       is_jmp;
    logic       is_branch;
    logic [1:0] br_cond;
    logic       is_halt;
  } op_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode -> instruction-class decode.
module opcode_decoder
  import controller_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls
);

  always_comb begin
    cls          = '0;
    cls.is_rtype = (opcode[5:4] == CLS_RTYPE);
    cls.is_itype = (opcode[5:4] == CLS_ITYPE);
    cls.is_lw    = (opcode[5:3] == CLS_LW);
    cls.is_sw    = (opcode[5:3] == CLS_SW);
    cls.is_shift = (opcode[5:2] == CLS_SHIFT);
    case (opcode)
      OP_JMP:  cls.is_jmp = 1'b1;
      OP_BZ:   begin cls.is_branch = 1'b1; cls.br_cond = BR_Z;  end
      OP_BNZ:  begin cls.is_branch = 1'b1; cls.br_cond = BR_NZ; end
      OP_BC:   begin cls.is_branch = 1'b1; cls.br_cond = BR_C;  end
      OP_BNC:  begin cls.is_branch = 1'b1; cls.br_cond = BR_NC; end
      OP_HALT: cls.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with memory wait
// states and architectural Z/C flags for conditional branches.
module multicycle_controller
  import controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_cout,
  input  logic                shift_c,
  input  logic                imem_ready,
  input  logic                dmem_ack,
  output logic                ir_write,
  output logic                pc_write,
  output logic                sel_pc_plus1,
  output logic                sel_pc_const,
  output logic                sel_pc_offset,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel_alusrc_const,
  output logic                mem_read,
  output logic                mem_write,
  output logic                sel_rf_in_alu,
  output logic                sel_rf_in_mem,
  output logic                sel_rf_in_shift,
  output logic                rf_write_en,
  output logic                sel_rf_dst_r2,
  output logic                sel_rf_read2_rd,
  output logic                flag_z,
  output logic                flag_c,
  output logic                halted
);

  op_class_t cls;
  state_t    state_q, state_d;
  logic      is_alu;
  logic      br_taken;
  logic      flag_upd;

  opcode_decoder u_opcode_decoder (
    .opcode (opcode),
    .cls    (cls)
  );

  assign is_alu = cls.is_rtype | cls.is_itype;

  // Branch conditions look only at the architectural flags
  always_comb begin
    br_taken = 1'b0;
    case (cls.br_cond)
      BR_Z:    br_taken = flag_z;
      BR_NZ:   br_taken = ~flag_z;
      BR_C:    br_taken = flag_c;
      BR_NC:   br_taken = ~flag_c;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Flags are written on the WB edge of ALU/SHIFT instructions only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (flag_upd) begin
      flag_z <= alu_zero;
      flag_c <= cls.is_shift ? shift_c : alu_cout;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_d          = state_q;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    sel_pc_plus1     = 1'b0;
    sel_pc_const     = 1'b0;
    sel_pc_offset    = 1'b0;
    alu_op           = opcode[3:1];
    sel_alusrc_const = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    sel_rf_in_alu    = 1'b0;
    sel_rf_in_mem    = 1'b0;
    sel_rf_in_shift  = 1'b0;
    rf_write_en      = 1'b0;
    sel_rf_dst_r2    = 1'b0;
    sel_rf_read2_rd  = 1'b0;
    halted           = 1'b0;
    flag_upd         = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: state_d = cls.is_halt ? S_HALT : S_EXEC;

      S_EXEC: begin
        if (is_alu || cls.is_shift) begin
          sel_alusrc_const = cls.is_itype;
          state_d          = S_WB;
        end else if (cls.is_lw || cls.is_sw) begin
          alu_op           = ALU_ADD;
          sel_alusrc_const = 1'b1;
          state_d          = S_MEM;
        end else begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
          if (cls.is_jmp)                     sel_pc_const  = 1'b1;
          else if (cls.is_branch && br_taken) sel_pc_offset = 1'b1;
          else                                sel_pc_plus1  = 1'b1;
        end
      end

      // Address stays on the ALU for the whole access
      S_MEM: begin
        alu_op           = ALU_ADD;
        sel_alusrc_const = 1'b1;
        if (cls.is_lw) begin
          mem_read = 1'b1;
          if (dmem_ack) state_d = S_WB;
        end else if (cls.is_sw) begin
          mem_write       = 1'b1;
          sel_rf_read2_rd = 1'b1;
          if (dmem_ack) begin
            pc_write     = 1'b1;
            sel_pc_plus1 = 1'b1;
            state_d      = S_FETCH;
          end
        end else begin
          pc_write     = 1'b1;
          sel_pc_plus1 = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_WB: begin
        rf_write_en      = 1'b1;
        pc_write         = 1'b1;
        sel_pc_plus1     = 1'b1;
        sel_alusrc_const = cls.is_itype;
        sel_rf_dst_r2    = cls.is_itype | cls.is_lw;
        flag_upd         = is_alu | cls.is_shift;
        if (cls.is_lw)         sel_rf_in_mem   = 1'b1;
        else if (cls.is_shift) sel_rf_in_shift = 1'b1;
        else                   sel_rf_in_alu   = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: random instruction stream compared against an
// instruction-level model of latency, strobes, selects and flags.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       alu_zero, alu_cout, shift_c, imem_ready, dmem_ack;
  logic       ir_write, pc_write, sel_pc_plus1, sel_pc_const, sel_pc_offset;
  logic [2:0] alu_op;
  logic       sel_alusrc_const, mem_read, mem_write;
  logic       sel_rf_in_alu, sel_rf_in_mem, sel_rf_in_shift;
  logic       rf_write_en, sel_rf_dst_r2, sel_rf_read2_rd;
  logic       flag_z, flag_c, halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: architectural flags
  logic mfz = 1'b0;
  logic mfc = 1'b0;
  logic       raw_force = 1'b0;
  logic [2:0] raw_val   = 3'b000;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_SH = 4, C_JMP = 5;
  localparam int C_BZ = 6, C_BNZ = 7, C_BC = 8, C_BNC = 9, C_NOP = 10;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .alu_zero(alu_zero), .alu_cout(alu_cout), .shift_c(shift_c),
    .imem_ready(imem_ready), .dmem_ack(dmem_ack),
    .ir_write(ir_write), .pc_write(pc_write),
    .sel_pc_plus1(sel_pc_plus1), .sel_pc_const(sel_pc_const), .sel_pc_offset(sel_pc_offset),
    .alu_op(alu_op), .sel_alusrc_const(sel_alusrc_const),
    .mem_read(mem_read), .mem_write(mem_write),
    .sel_rf_in_alu(sel_rf_in_alu), .sel_rf_in_mem(sel_rf_in_mem), .sel_rf_in_shift(sel_rf_in_shift),
    .rf_write_en(rf_write_en), .sel_rf_dst_r2(sel_rf_dst_r2), .sel_rf_read2_rd(sel_rf_read2_rd),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] out_vec();
    return {ir_write, pc_write, sel_pc_plus1, sel_pc_const, sel_pc_offset,
            sel_alusrc_const, mem_read, mem_write, sel_rf_in_alu, sel_rf_in_mem,
            sel_rf_in_shift, rf_write_en, sel_rf_dst_r2, sel_rf_read2_rd,
            flag_z, flag_c, halted};
  endfunction

  function automatic logic [5:0] make_opcode(input int c);
    logic [5:0] r;
    r = 6'($urandom);
    case (c)
      C_R:     return {2'b00, r[3:0]};
      C_I:     return {2'b01, r[3:0]};
      C_LW:    return {3'b100, r[2:0]};
      C_SW:    return {3'b101, r[2:0]};
      C_SH:    return {4'b1100, r[1:0]};
      C_JMP:   return 6'b110100;
      C_BZ:    return 6'b110101;
      C_BNZ:   return 6'b110110;
      C_BC:    return 6'b110111;
      C_BNC:   return 6'b111000;
      default: return 6'(6'b111001 + 6'($urandom_range(0, 5)));
    endcase
  endfunction

  task automatic drive_raw();
    if (raw_force) {alu_zero, alu_cout, shift_c} = raw_val;
    else           {alu_zero, alu_cout, shift_c} = 3'($urandom);
  endtask

  // One instruction: fw fetch wait cycles, mw data wait cycles
  task automatic run_instr(input int c, input int fw, input int mw);
    logic [5:0] op;
    bit   is_alu, is_mem, wr_rf, taken;
    int   lat, n_irw, irw_k, n_pcw, pcw_k, n_rfw, n_mr, n_mw, bad, n_halt;
    logic [2:0] pcsel, exp_pcsel, rfin, exp_rfin;
    logic dst, wb_z, wb_c, wb_s, ex_src;
    logic [2:0] ex_op;
    op     = make_opcode(c);
    is_alu = (c == C_R) || (c == C_I) || (c == C_SH);
    is_mem = (c == C_LW) || (c == C_SW);
    wr_rf  = is_alu || (c == C_LW);
    if (is_alu)          lat = fw + 4;
    else if (c == C_SW)  lat = fw + 4 + mw;
    else if (c == C_LW)  lat = fw + 5 + mw;
    else                 lat = fw + 3;
    taken = (c == C_BZ && mfz) || (c == C_BNZ && !mfz) ||
            (c == C_BC && mfc) || (c == C_BNC && !mfc);
    if (c == C_JMP)  exp_pcsel = 3'b010;
    else if (taken)  exp_pcsel = 3'b001;
    else             exp_pcsel = 3'b100;
    if (c == C_LW)       exp_rfin = 3'b010;
    else if (c == C_SH)  exp_rfin = 3'b001;
    else                 exp_rfin = 3'b100;
    n_irw = 0; irw_k = -1; n_pcw = 0; pcw_k = -1; n_rfw = 0; n_mr = 0; n_mw = 0;
    bad = 0; n_halt = 0; pcsel = '0; rfin = '0; dst = 1'b0;
    wb_z = 1'b0; wb_c = 1'b0; wb_s = 1'b0; ex_op = '0; ex_src = 1'b0;
    opcode = op;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k < fw)       imem_ready = 1'b0;
      else if (k == fw) imem_ready = 1'b1;
      else              imem_ready = 1'($urandom);
      if (is_mem && k >= fw + 3 && k <= fw + 3 + mw) dmem_ack = (k == fw + 3 + mw);
      else                                           dmem_ack = 1'($urandom);
      drive_raw();
      if (k == lat - 1) {wb_z, wb_c, wb_s} = {alu_zero, alu_cout, shift_c};
      #1;
      if (ir_write) begin n_irw++; irw_k = k; end
      if (pc_write) begin n_pcw++; pcw_k = k; pcsel = {sel_pc_plus1, sel_pc_const, sel_pc_offset}; end
      if (rf_write_en) begin
        n_rfw++;
        rfin = {sel_rf_in_alu, sel_rf_in_mem, sel_rf_in_shift};
        dst  = sel_rf_dst_r2;
      end
      n_mr += int'(mem_read);
      n_mw += int'(mem_write);
      n_halt += int'(halted);
      if (mem_write && !sel_rf_read2_rd) bad++;
      if (!$onehot0({sel_pc_plus1, sel_pc_const, sel_pc_offset})) bad++;
      if (!$onehot0({sel_rf_in_alu, sel_rf_in_mem, sel_rf_in_shift})) bad++;
      if (!pc_write && (sel_pc_plus1 | sel_pc_const | sel_pc_offset)) bad++;
      if (!rf_write_en && (sel_rf_in_alu | sel_rf_in_mem | sel_rf_in_shift)) bad++;
      if (k == fw + 2) begin ex_op = alu_op; ex_src = sel_alusrc_const; end
    end
    check("ir_write_count", n_irw, 1);
    check("ir_write_cycle", irw_k, fw);
    check("pc_write_count", n_pcw, 1);
    check("pc_write_cycle", pcw_k, lat - 1);
    check("pc_source", pcsel, exp_pcsel);
    check("rf_write_count", n_rfw, wr_rf ? 1 : 0);
    if (wr_rf) begin
      check("rf_in_select", rfin, exp_rfin);
      check("rf_dst_r2", dst, (c == C_I) || (c == C_LW));
    end
    check("mem_read_cycles", n_mr, (c == C_LW) ? mw + 1 : 0);
    check("mem_write_cycles", n_mw, (c == C_SW) ? mw + 1 : 0);
    check("select_groups", bad, 0);
    check("halted_low", n_halt, 0);
    if (is_mem) begin
      check("exec_alu_op", ex_op, 3'b000);
      check("exec_alusrc", ex_src, 1'b1);
    end else if (is_alu) begin
      check("exec_alu_op", ex_op, op[3:1]);
      check("exec_alusrc", ex_src, c == C_I);
    end
    if (is_alu) begin
      mfz = wb_z;
      mfc = (c == C_SH) ? wb_s : wb_c;
    end
    @(posedge clk);
    #1;
    check("flag_z", flag_z, mfz);
    check("flag_c", flag_c, mfc);
  endtask

  // SW interrupted by reset while waiting for dmem_ack
  task automatic sw_reset();
    opcode = make_opcode(C_SW);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ready = (k == 0) ? 1'b1 : 1'($urandom);
      dmem_ack   = (k == 3) ? 1'b0 : 1'($urandom);
      drive_raw();
    end
    imem_ready = 1'b0;
    #1 check("sw_mem_write", mem_write, 1'b1);
    #2 rst = 1'b0;
    #1 check("sw_async_drop", mem_write, 1'b0);
    check("reset_outputs_mid", out_vec(), 17'h0);
    mfz = 1'b0;
    mfc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_reset_flags", {flag_z, flag_c}, 2'b00);
    imem_ready = 1'b1;
    #1 check("post_reset_fetch", ir_write, 1'b1);
    imem_ready = 1'b0;
  endtask

  task automatic run_halt(input int fw);
    int n_wr, n_h;
    n_wr = 0; n_h = 0;
    opcode = 6'b111111;
    for (int k = 0; k <= fw + 24; k++) begin
      @(negedge clk);
      if (k < fw)       imem_ready = 1'b0;
      else if (k == fw) imem_ready = 1'b1;
      else              imem_ready = 1'($urandom);
      dmem_ack = 1'($urandom);
      drive_raw();
      #1;
      if (k == fw + 1) check("halted_in_decode", halted, 1'b0);
      if (k > fw) n_wr += int'(pc_write) + int'(ir_write);
      if (k >= fw + 2) n_h += int'(halted);
    end
    check("halt_no_writes", n_wr, 0);
    check("halt_cycles", n_h, 23);
  endtask

  initial begin
    rst = 1'b0; opcode = '0;
    alu_zero = 1'b0; alu_cout = 1'b0; shift_c = 1'b0;
    imem_ready = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", out_vec(), 17'h0);
    @(negedge clk);
    rst = 1'b1;

    raw_force = 1'b1; raw_val = 3'b111;
    run_instr(C_R, 0, 0);
    raw_force = 1'b0;
    run_instr(C_BZ, 0, 0);
    run_instr(C_LW, 0, 3);
    raw_force = 1'b1; raw_val = 3'b001;
    run_instr(C_SH, 0, 0);
    raw_force = 1'b0;
    run_instr(C_BZ, 1, 0);
    run_instr(C_SW, 0, 0);

    for (int i = 0; i < 150; i++)
      run_instr(int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));

    raw_force = 1'b1; raw_val = 3'b111;
    run_instr(C_I, 0, 0);
    raw_force = 1'b0;
    sw_reset();
    for (int i = 0; i < 20; i++)
      run_instr(int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    run_halt(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the 8-bit/19-bit-instruction processor datapath. It replaces the single-cycle combinational controller with a state machine that splits each instruction into fetch, decode, execute, memory and writeback steps. It also adds wait-state handshakes to instruction and data memory, and keeps architectural Z/C flag registers for conditional branches. It sits beside the datapath: it reads the instruction-register opcode and the raw flags, and drives every datapath select and enable.

## Interface
Parameters:
- None. Widths are fixed by the instruction set.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 6: `instruction[18:13]`, taken from the instruction register.
- `alu_zero` in 1: combinational zero flag from the datapath.
- `alu_cout` in 1: ALU carry-out.
- `shift_c` in 1: shifter carry-out.
- `imem_ready` in 1: instruction word is valid this cycle.
- `dmem_ack` in 1: data memory has completed the current read or write.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC from the selected PC source.
- `sel_pc_plus1`, `sel_pc_const`, `sel_pc_offset` out 1 each: PC source select, one-hot.
- `alu_op` out 3: ALU function. Equals `opcode[3:1]`.
- `sel_alusrc_const` out 1: 1 selects the immediate, 0 selects register 2.
- `mem_read`, `mem_write` out 1 each: data memory strobes.
- `sel_rf_in_alu`, `sel_rf_in_mem`, `sel_rf_in_shift` out 1 each: register-file write data select, one-hot.
- `rf_write_en` out 1: register-file write enable.
- `sel_rf_dst_r2` out 1: write destination is `instruction[10:8]`.
- `sel_rf_read2_rd` out 1: read port 2 uses the rd field (for SW data).
- `flag_z`, `flag_c` out 1 each: architectural flags.
- `halted` out 1: controller is in HALT.

## Operation
Opcode classes (`opcode` bits):
- `00xxxx`: R-type ALU.
- `01xxxx`: I-type ALU.
- `100xxx`: LW.
- `101xxx`: SW.
- `1100xx`: SHIFT.
- `110100`: JMP.
- `110101`: BZ.
- `110110`: BNZ.
- `110111`: BC.
- `111000`: BNC.
- `111111`: HALT.
- All other codes execute as NOP.

FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH:** hold until `imem_ready`. On the cycle `imem_ready`=1: `ir_write`=1, go to DECODE.
- **DECODE:** one cycle, no enables.
  - HALT opcode → HALT.
  - Otherwise → EXEC.
- **EXEC:**
  - ALU/SHIFT: drive `alu_op` and src select, go to WB.
  - LW/SW: `alu_op`=ADD (000), `sel_alusrc_const`=1, go to MEM.
  - JMP: `pc_write`=1, `sel_pc_const`, go to FETCH.
  - Branch taken: `pc_write`=1, `sel_pc_offset`, go to FETCH.
  - Branch not taken and NOP: `pc_write`=1, `sel_pc_plus1`, go to FETCH.
  - Branch conditions use the registered `flag_z`/`flag_c`, never the raw inputs.
- **MEM:**
  - LW: `mem_read`=1 held until `dmem_ack`, then → WB.
  - SW: `mem_write`=1 and `sel_rf_read2_rd`=1 held. On the `dmem_ack` cycle also `pc_write`=1 with `sel_pc_plus1`, then → FETCH.
- **WB:** `rf_write_en`=1, `pc_write`=1, `sel_pc_plus1`. Write-data select:
  - `sel_rf_in_mem` for LW.
  - `sel_rf_in_shift` for SHIFT.
  - `sel_rf_in_alu` otherwise.
  - I-type and LW set `sel_rf_dst_r2`=1.
- **HALT:** absorbing. `halted`=1 and all enables 0. Only reset exits.

Flags:
- Updated only on the WB clock edge of ALU/SHIFT instructions.
- `flag_z` ← `alu_zero`.
- `flag_c` ← `alu_cout` for ALU instructions, `shift_c` for SHIFT.
- LW, SW, branches and NOP leave the flags unchanged.

Outputs:
- All outputs are combinational from the state register and `opcode`.
- `ir_write` and the MEM-exit `pc_write` additionally depend on `imem_ready`/`dmem_ack` (Mealy).
- All one-hot select groups are all-zero when unused.

## Timing
- Reset (`rst`=0, asynchronous): state=FETCH, `flag_z`=`flag_c`=0, `halted`=0, every enable and strobe 0.
  - Reset in the middle of MEM drops `mem_read`/`mem_write` immediately, without waiting for a clock edge.
- Latency with zero wait states:
  - Branch/JMP/NOP: 3 cycles.
  - ALU/SHIFT: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds one.
- `imem_ready`/`dmem_ack` are sampled only in FETCH/MEM. Asserting them in any other state has no effect.
- `dmem_ack` arriving in the same cycle the strobe is first asserted completes MEM in one cycle.
- Exactly one `pc_write` pulse per instruction. None in HALT.
- A branch immediately following a flag-setting instruction sees that instruction's flags.

## Structure
- Package `controller_pkg`:
  - `state_t` enum.
  - Opcode-class constants.
  - `ALU_ADD` constant.
  - Decoded-class struct: `is_rtype`, `is_itype`, `is_lw`, `is_sw`, `is_shift`, `is_jmp`, `is_branch`, `br_cond[1:0]`, `is_halt`.
- Sub-module `opcode_decoder`: purely combinational, `opcode` → class struct.
- Top level holds the state register, the flag registers and the output logic.

## Test plan
1. Reset released, `imem_ready`=1, R-type ADD with `alu_zero`=1, `alu_cout`=1:
   - States FETCH→DECODE→EXEC→WB.
   - `rf_write_en` only in WB, `flag_z`=`flag_c`=1 after WB.
   - 4 cycles.
2. LW with `dmem_ack` delayed 3 cycles:
   - `mem_read` high for 4 cycles.
   - WB with `sel_rf_in_mem`=1.
   - 8 cycles total.
3. BZ:
   - With `flag_z`=1: `sel_pc_offset` with `pc_write`.
   - With `flag_z`=0: `sel_pc_plus1`.
   - Raw `alu_zero` toggling during EXEC changes neither outcome.
4. SHIFT with `shift_c`=1, `alu_cout`=0: `flag_c`=1 after WB, `sel_rf_in_shift`=1.
5. SW, then reset asserted during MEM before `dmem_ack`:
   - `mem_write` falls asynchronously.
   - After reset release: state FETCH, flags 0.
6. HALT opcode:
   - `halted`=1 from the cycle after DECODE.
   - No `pc_write`/`ir_write` for 20 cycles regardless of `imem_ready`.
